// File: rtl/uart_mm_pkg.sv
// Shared command/response codes and decoder state encoding for the UART memory-mapped path.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package uart_mm_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GET_ADDR  = 3'd1,
        ST_GET_DATA  = 3'd2,
        ST_WRITE     = 3'd3,
        ST_READ      = 3'd4,
        ST_READ_WAIT = 3'd5,
        ST_SEND      = 3'd6
    } state_t;

    // Increment that sticks at 0xFF instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_mm_byte_timer.sv
// Inter-byte idle timer: counts enabled cycles, pulses o_tc on the last allowed idle cycle.
// Latency: o_tc is combinational from the count; a clear takes effect on the next edge.
// Backpressure: none; clear has priority over counting.
module uart_mm_byte_timer #(
    parameter int TimeoutCycles = 1000000,
    parameter int TimeoutWidth  = 20
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tc
);

    localparam logic [TimeoutWidth-1:0] LP_LAST = TimeoutWidth'(TimeoutCycles - 1);

    logic [TimeoutWidth-1:0] r_count;

    // Idle-cycle counter: cleared by an accepted byte or whenever no frame is in progress.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + TimeoutWidth'(1);
        end
    end

    // A byte arriving on the terminal cycle clears the timer, so it suppresses the pulse.
    assign o_tc = i_en & ~i_clr & (r_count == LP_LAST);

endmodule

// File: rtl/uart_mm_cmd_decoder.sv
// Parses 'W' addr data / 'R' addr frames from the RX byte stream into register bus strobes; one response byte per command.
// Latency: write strobe 1 cycle after last byte, response 2 cycles; read strobe 1 cycle after addr, response 3 cycles.
// Backpressure: RX is stalled (o_rx_ready=0) outside the byte-collecting states; the response waits on i_tx_ready indefinitely.
module uart_mm_cmd_decoder
    import uart_mm_pkg::*;
#(
    parameter int TimeoutCycles = 1000000,
    parameter int TimeoutWidth  = 20
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_valid,
    output logic       o_rx_ready,
    input  logic [7:0] i_rx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    output logic [7:0] o_tx_data,
    output logic       o_reg_wr_en,
    output logic       o_reg_rd_en,
    output logic [7:0] o_reg_addr,
    output logic [7:0] o_reg_wdata,
    input  logic [7:0] i_reg_rdata,
    output logic [7:0] o_err_count
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_op_wr;
    logic       r_rdy_en;
    logic [7:0] r_tx_data;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_err;

    logic       w_in_frame;
    logic       w_rx_fire;
    logic       w_tc;
    logic       w_err_inc;
    logic       w_known_cmd;

    assign w_in_frame  = (r_state == ST_GET_ADDR) | (r_state == ST_GET_DATA);
    // r_rdy_en keeps o_rx_ready low while in reset and until the first clock after release.
    assign o_rx_ready  = r_rdy_en & (w_in_frame | (r_state == ST_IDLE));
    assign w_rx_fire   = i_rx_valid & o_rx_ready;
    assign w_known_cmd = (i_rx_data == CMD_WRITE) | (i_rx_data == CMD_READ);

    assign o_tx_valid  = (r_state == ST_SEND);
    assign o_tx_data   = r_tx_data;
    assign o_reg_wr_en = (r_state == ST_WRITE);
    assign o_reg_rd_en = (r_state == ST_READ);
    assign o_reg_addr  = r_addr;
    assign o_reg_wdata = r_wdata;
    assign o_err_count = r_err;

    uart_mm_byte_timer #(
        .TimeoutCycles (TimeoutCycles),
        .TimeoutWidth  (TimeoutWidth)
    ) u_byte_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_in_frame),
        .i_clr   (w_rx_fire | ~w_in_frame),
        .o_tc    (w_tc)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an accepted byte always takes priority over the idle timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_err_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rx_fire) begin
                    if (w_known_cmd) begin
                        w_state_nxt = ST_GET_ADDR;
                    end else begin
                        w_state_nxt = ST_SEND;
                        w_err_inc   = 1'b1;
                    end
                end
            end
            ST_GET_ADDR: begin
                if (w_rx_fire) begin
                    w_state_nxt = r_op_wr ? ST_GET_DATA : ST_READ;
                end else if (w_tc) begin
                    w_state_nxt = ST_IDLE;
                    w_err_inc   = 1'b1;
                end
            end
            ST_GET_DATA: begin
                if (w_rx_fire) begin
                    w_state_nxt = ST_WRITE;
                end else if (w_tc) begin
                    w_state_nxt = ST_IDLE;
                    w_err_inc   = 1'b1;
                end
            end
            ST_WRITE:     w_state_nxt = ST_SEND;
            ST_READ:      w_state_nxt = ST_READ_WAIT;
            ST_READ_WAIT: w_state_nxt = ST_SEND;
            ST_SEND: begin
                if (i_tx_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    // Frame latches, response byte and saturating error counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdy_en  <= 1'b0;
            r_op_wr   <= 1'b0;
            r_tx_data <= 8'h00;
            r_addr    <= 8'h00;
            r_wdata   <= 8'h00;
            r_err     <= 8'h00;
        end else begin
            r_rdy_en <= 1'b1;
            if (r_state == ST_IDLE && w_rx_fire) begin
                r_op_wr <= (i_rx_data == CMD_WRITE);
                if (!w_known_cmd) begin
                    r_tx_data <= RSP_NAK;
                end
            end
            if (r_state == ST_GET_ADDR && w_rx_fire) begin
                r_addr <= i_rx_data;
            end
            if (r_state == ST_GET_DATA && w_rx_fire) begin
                r_wdata <= i_rx_data;
            end
            if (r_state == ST_WRITE) begin
                r_tx_data <= RSP_ACK;
            end
            if (r_state == ST_READ_WAIT) begin
                r_tx_data <= i_reg_rdata;
            end
            if (w_err_inc) begin
                r_err <= sat_inc8(r_err);
            end
        end
    end

endmodule

// File: doc/uart_mm_cmd_decoder.md
Name: uart_mm_cmd_decoder

Overview:
Command-layer stage that sits directly downstream of the UART receiver and upstream of the UART transmitter in the memory-mapped LED path. It parses the received byte stream into register read/write transactions on a simple 8-bit register bus. It returns one response byte per command through the transmit stream. It feeds the LED/reset register file and drives its bus.

Parameters:
TimeoutCycles, 1000000, idle clock cycles allowed between bytes of one frame before the frame is abandoned (about 6.4 ms at 156.25 MHz).
TimeoutWidth, 20, counter width; must satisfy 2**TimeoutWidth > TimeoutCycles.

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_rx_valid  input  1  received byte available
o_rx_ready  output  1  decoder accepts the byte this cycle
i_rx_data  input  8  received byte
o_tx_valid  output  1  response byte available
i_tx_ready  input  1  transmitter accepts the byte
o_tx_data  output  8  response byte
o_reg_wr_en  output  1  register write strobe, one cycle
o_reg_rd_en  output  1  register read strobe, one cycle
o_reg_addr  output  8  register address
o_reg_wdata  output  8  register write data
i_reg_rdata  input  8  read data, valid exactly 1 cycle after o_reg_rd_en
o_err_count  output  8  saturating count of NAKs plus timeouts

Behaviour:
- Reset is asynchronous and active-low, on i_clk. While i_rst_n=0 and after release:
  - all outputs are 0;
  - state is IDLE;
  - timeout counter is 0.
- Reset asserted mid-frame or mid-send drops the frame and any pending response. Nothing is replayed.
- Frame formats:
  - write: 0x57 ('W'), addr, data.
  - read: 0x52 ('R'), addr.
  - any other first byte is an unknown command.
- Byte transfer occurs on i_rx_valid & o_rx_ready.
- o_rx_ready=1 only in IDLE, GET_ADDR and GET_DATA. It is combinational from state.
- IDLE:
  - byte 0x57 -> GET_ADDR, op=write.
  - byte 0x52 -> GET_ADDR, op=read.
  - any other byte -> SEND with o_tx_data=0x15 (NAK); o_err_count increments.
- GET_ADDR:
  - on a transfer, latch o_reg_addr.
  - op=write -> GET_DATA.
  - op=read -> READ.
- GET_DATA: on a transfer, latch o_reg_wdata -> WRITE.
- WRITE: o_reg_wr_en=1 for exactly this cycle -> SEND with 0x06 (ACK).
- READ: o_reg_rd_en=1 for exactly this cycle -> READ_WAIT.
- READ_WAIT: capture i_reg_rdata into o_tx_data -> SEND.
- SEND:
  - o_tx_valid=1 with o_tx_data held stable until i_tx_ready=1.
  - on the handshake cycle -> IDLE.
  - No timeout applies in SEND; backpressure may last indefinitely.
- Latency:
  - last write byte accepted at cycle N -> wr_en at N+1 -> o_tx_valid from N+2.
  - read addr accepted at cycle N -> rd_en at N+1 -> data captured at N+2 -> o_tx_valid from N+3.
- o_reg_addr and o_reg_wdata hold their last values between transactions.
- Timeout:
  - the counter runs only in GET_ADDR and GET_DATA;
  - it clears on every accepted byte and on entry to IDLE.
  - When it reaches TimeoutCycles-1 with no transfer, the state goes to IDLE with no response byte, and o_err_count increments.
  - A transfer on the same cycle the limit is reached wins: the byte is taken and no timeout occurs.
- o_err_count saturates at 0xFF and clears only on reset.
- o_reg_wr_en and o_reg_rd_en are never asserted together.

Decomposition:
- Shared package uart_mm_pkg holds:
  - command codes CMD_WRITE=8'h57 and CMD_READ=8'h52;
  - response codes RSP_ACK=8'h06 and RSP_NAK=8'h15;
  - the state encoding localparams (IDLE, GET_ADDR, GET_DATA, WRITE, READ, READ_WAIT, SEND).
- One natural sub-module is uart_mm_byte_timer, holding the clearable, enable-gated timeout counter with a terminal-count pulse.
- The FSM, the latches and the error counter stay in the top level.

Test Plan:
- Write: send 0x57, 0xA5, 0x3C with i_tx_ready=1 -> one wr_en pulse with addr=0xA5 and wdata=0x3C, then tx byte 0x06; err_count=0.
- Read: send 0x52, 0x10 with i_reg_rdata=0x99 the cycle after rd_en -> one rd_en pulse with addr=0x10, then tx byte 0x99 at N+3.
- Bad command plus saturation: send 0x41 -> tx 0x15 and err_count=1. Send 300 bad bytes -> err_count=0xFF.
- Timeout: send 0x57, 0x01, then nothing for TimeoutCycles (set to 50) -> return to IDLE, no tx, no wr_en, err_count=1. A following 0x52, 0x01 completes normally.
- Backpressure: hold i_tx_ready=0 for 200 cycles after a write -> o_tx_valid stays 1, o_tx_data stays 0x06, o_rx_ready=0, no timeout. Release -> one handshake, back to IDLE.
- Reset mid-frame: drop i_rst_n after 0x57, 0x22 -> all outputs 0 asynchronously. After release, 0x33 is treated as a new command byte and produces NAK 0x15.
